ps2_kb_rx: RTL and testbench
============================

PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum CLOCK_50 cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- REQ-002 SHALL use one clock and a synchronous, active-high reset; the clock port SHALL be named CLOCK_50 and the reset port reset.
- REQ-003 CLOCK_50  in  1  system clock; all state updates on its rising edge.
- REQ-004 reset  in  1  synchronous active-high reset.
- REQ-005 PS2_KBCLK  in  1  asynchronous PS/2 keyboard clock pin.
- REQ-006 PS2_KBDAT  in  1  asynchronous PS/2 keyboard data pin.
- REQ-007 rd_en  in  1  pop request from the core; ignored while empty.
- REQ-008 err_clr  in  1  clears the sticky error flags.
- REQ-009 data  out  8  scan code at the FIFO head (first-word-fall-through); 0x00 when empty.
- REQ-010 empty  out  1  FIFO holds no bytes.
- REQ-011 full  out  1  FIFO holds 4 bytes.
- REQ-012 count  out  3  number of bytes held, 0..4.
- REQ-013 busy  out  1  receiver FSM is not IDLE.
- REQ-014 parity_err, frame_err, overflow  out  1 each  sticky error flags.

Function
- REQ-015 PS2_KBCLK and PS2_KBDAT SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be registered when the previous synchronized clock is 1 and the current one is 0.
- REQ-016 Data SHALL be sampled from the synchronized data line only in cycles in which a falling edge is registered.
- REQ-017 FSM states SHALL be IDLE and RECV.
- REQ-018 In IDLE, an edge with data=0 (start bit) SHALL move to RECV with bit count 0; an edge with data=1 SHALL be ignored.
- REQ-019 In RECV, bits SHALL be taken in order: 8 data bits LSB first, parity bit, stop bit; the FSM SHALL return to IDLE on the stop-bit edge.
- REQ-020 A frame SHALL be valid when data plus parity has an odd number of ones and stop=1.
- REQ-021 A valid frame SHALL be pushed to the FIFO so that empty=0 and data show the byte in the cycle after the stop-bit edge is registered.
- REQ-022 Bad parity SHALL set parity_err and discard the byte; stop=0 SHALL set frame_err and discard the byte; if both occur, both flags SHALL be set.
- REQ-023 A cycle counter SHALL reset on every edge in RECV.
- REQ-024 If the cycle counter reaches TIMEOUT_CYCLES in RECV, the FSM SHALL abort to IDLE and discard partial bits, with no flag set.
- REQ-025 The FIFO SHALL be 4 deep with pointers wrapping modulo 4.
- REQ-026 rd_en with empty=0 SHALL advance the head in the same clock edge.
- REQ-027 A push with full=1 and no pop SHALL drop the new byte and set overflow.
- REQ-028 A push and a pop in the same cycle SHALL both take effect with count unchanged, including when full, and SHALL NOT set overflow.
- REQ-029 err_clr SHALL clear all three sticky flags; if a flag's set condition occurs in the same cycle, set SHALL win.

Reset
- REQ-030 On reset, the FSM SHALL go to IDLE, bit and timeout counters and FIFO pointers SHALL go to 0, and the synchronizers SHALL load 1.
- REQ-031 Reset values SHALL be: data=0x00, empty=1, full=0, count=0, busy=0, parity_err=0, frame_err=0, overflow=0.
- REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the next start bit SHALL be received normally.

Verification (bench: TIMEOUT_CYCLES=1000, PS/2 bit period 200 cycles)
- REQ-033 Send frame 0x1C (parity 0, stop 1) -> one cycle after the stop edge: data=0x1C, empty=0, count=1, no flags; rd_en for 1 cycle -> empty=1.
- REQ-034 Send 0x1C with parity 1 -> parity_err=1, empty=1; then err_clr -> parity_err=0. Send 0xF0 with stop=0 -> frame_err=1, empty=1.
- REQ-035 Send 0x01..0x05 with no reads -> count=4, full=1, overflow=1; popping returns 0x01,0x02,0x03,0x04, then empty=1.
- REQ-036 With FIFO full, assert rd_en in the cycle 0x06 is pushed -> count stays 4, overflow unchanged; pop order is 0x02,0x03,0x04,0x06.
- REQ-037 Send a start bit and 3 data bits, then idle 1000 cycles -> busy=0, FIFO unchanged; then send 0xF0 (parity 1) -> data=0xF0.
- REQ-038 Assert reset after 5 bits of a frame -> all outputs at reset values; the next 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deframes 11-bit frames and
// queues valid scan codes in a 4-entry first-word-fall-through FIFO with sticky error flags.
module ps2_kb_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] data,
    output logic       empty,
    output logic       full,
    output logic [2:0] count,
    output logic       busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    logic             r_kclk_s1;
    logic             r_kclk_s2;
    logic             r_kclk_d;
    logic             r_kdat_s1;
    logic             r_kdat_s2;

    state_t           r_state;
    logic [3:0]       r_bitcnt;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_shift;
    logic             r_par;

    logic [7:0]       r_mem [4];
    logic [1:0]       r_wp;
    logic [1:0]       r_rp;
    logic [2:0]       r_cnt;

    logic             r_perr;
    logic             r_ferr;
    logic             r_ovf;

    logic             w_fall;
    logic             w_bit;
    logic             w_par_ok;
    logic             w_stop_edge;
    logic             w_frame_ok;
    logic             w_set_perr;
    logic             w_set_ferr;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_set_ovf;

    // Pin synchronisers; idle-high lines so reset loads 1 and no false edge appears
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_kclk_s1 <= 1'b1;
            r_kclk_s2 <= 1'b1;
            r_kclk_d  <= 1'b1;
            r_kdat_s1 <= 1'b1;
            r_kdat_s2 <= 1'b1;
        end else begin
            r_kclk_s1 <= PS2_KBCLK;
            r_kclk_s2 <= r_kclk_s1;
            r_kclk_d  <= r_kclk_s2;
            r_kdat_s1 <= PS2_KBDAT;
            r_kdat_s2 <= r_kdat_s1;
        end
    end

    assign w_fall      = r_kclk_d & ~r_kclk_s2;
    assign w_bit       = r_kdat_s2;
    assign w_par_ok    = ^{r_shift, r_par};
    assign w_stop_edge = (r_state == S_RECV) && w_fall && (r_bitcnt == 4'd9);
    assign w_frame_ok  = w_stop_edge && w_bit && w_par_ok;
    assign w_set_perr  = w_stop_edge && !w_par_ok;
    assign w_set_ferr  = w_stop_edge && !w_bit;

    // Bit counter: 0-7 data LSB first, 8 parity, 9 stop
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bitcnt <= 4'd0;
                    r_tmo    <= '0;
                    if (w_fall && !w_bit) begin
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_fall) begin
                        r_tmo <= '0;
                        if (r_bitcnt == 4'd9) begin
                            r_state  <= S_IDLE;
                            r_bitcnt <= 4'd0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES)) begin
                        r_state  <= S_IDLE;
                        r_bitcnt <= 4'd0;
                        r_tmo    <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_bitcnt <= 4'd0;
                    r_tmo    <= '0;
                end
            endcase
        end
    end

    // Frame datapath: shifts in on data-bit edges, no reset needed
    always_ff @(posedge CLOCK_50) begin
        if ((r_state == S_RECV) && w_fall) begin
            if (r_bitcnt < 4'd8) begin
                r_shift <= {w_bit, r_shift[7:1]};
            end else if (r_bitcnt == 4'd8) begin
                r_par <= w_bit;
            end
        end
    end

    assign w_full    = (r_cnt == 3'd4);
    assign w_pop     = rd_en && (r_cnt != 3'd0);
    assign w_wr      = w_frame_ok && (!w_full || w_pop);
    assign w_set_ovf = w_frame_ok && w_full && !w_pop;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 2'd1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 2'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_wr) begin
            r_mem[r_wp] <= r_shift;
        end
    end

    // Sticky flags: a set in the same cycle as err_clr takes priority
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (err_clr) begin
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
                r_ovf  <= 1'b0;
            end
            if (w_set_perr) begin
                r_perr <= 1'b1;
            end
            if (w_set_ferr) begin
                r_ferr <= 1'b1;
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign data       = (r_cnt == 3'd0) ? 8'h00 : r_mem[r_rp];
    assign empty      = (r_cnt == 3'd0);
    assign full       = w_full;
    assign count      = r_cnt;
    assign busy       = (r_state == S_RECV);
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Bench for ps2_kb_rx: drives PS/2 frames, scoreboards received scan codes and flags.
module tb_ps2_kb_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       kclk;
    logic       kdat;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        bit         pflip;
        bit         stop;
        bit         eperr;
        bit         eferr;
    } vec_t;

    vec_t vecs[7];

    always #10 clk = ~clk;

    ps2_kb_rx #(.TIMEOUT_CYCLES(1000)) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .PS2_KBCLK (kclk),
        .PS2_KBDAT (kdat),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .data      (data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .busy      (busy),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic pop_check(input string nm);
        logic [7:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, nothing expected", nm);
            return;
        end
        n_cmp--;
        e = exp_q.pop_front();
        chk({nm, "_empty"}, empty, 0);
        chk({nm, "_data"}, data, e);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    // mode 0: plain bit; 1: pop in the cycle the byte is pushed; 2: check push latency
    task automatic send_bit(input logic v, input int mode, input logic [7:0] eb);
        logic [7:0] e;
        kdat = v;
        tick(50);
        kclk = 1'b0;
        tick(2);
        if (mode == 1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL simul_pop: scoreboard empty, nothing expected");
            end else begin
                n_cmp--;
                e = exp_q.pop_front();
                chk("simul_pop_data", data, e);
            end
            rd_en = 1'b1;
        end
        if (mode == 2) chk("pre_push_empty", empty, 1);
        tick(1);
        rd_en = 1'b0;
        if (mode == 2) begin
            chk("post_push_empty", empty, 0);
            chk("post_push_data", data, eb);
            chk("post_push_busy", busy, 0);
            chk("post_push_count", count, 1);
        end
        if (mode == 1) chk("simul_count", count, 4);
        tick(97);
        kclk = 1'b1;
        tick(50);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stop, input int mode);
        send_bit(1'b0, 0, b);
        for (int i = 0; i < 8; i++) send_bit(b[i], 0, b);
        send_bit((~^b) ^ pflip, 0, b);
        send_bit(stop, mode, b);
        if (stop && !pflip) exp_q.push_back(b);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; kclk = 1'b1; kdat = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(2);
        chk("rst_data", data, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);

        for (int i = 0; i < 7; i++) begin
            pulse_clr();
            chk("vec_clr_perr", parity_err, 0);
            chk("vec_clr_ferr", frame_err, 0);
            send_frame(vecs[i].b, vecs[i].pflip, vecs[i].stop, (i == 0) ? 2 : 0);
            chk("vec_perr", parity_err, vecs[i].eperr);
            chk("vec_ferr", frame_err, vecs[i].eferr);
            chk("vec_count", count, (vecs[i].eperr || vecs[i].eferr) ? 0 : 1);
            chk("vec_ovf", overflow, 0);
            while (exp_q.size() > 0) pop_check("vec_pop");
            chk("vec_empty", empty, 1);
        end

        // Five frames into a four-deep FIFO: the fifth is dropped
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        void'(exp_q.pop_back());
        chk("ovf_count", count, 4);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) pop_check("ovf_pop");
        chk("ovf_drained", empty, 1);

        // Push and pop in the same cycle while full
        pulse_clr();
        chk("pp_clr_ovf", overflow, 0);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        chk("pp_full", full, 1);
        send_frame(8'h06, 1'b0, 1'b1, 1);
        chk("pp_count", count, 4);
        chk("pp_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) pop_check("pp_pop");
        chk("pp_drained", empty, 1);

        // Partial frame then silence: receiver must abort quietly
        send_bit(1'b0, 0, 8'h00);
        send_bit(1'b1, 0, 8'h00);
        send_bit(1'b0, 0, 8'h00);
        send_bit(1'b1, 0, 8'h00);
        chk("tmo_busy_before", busy, 1);
        tick(1100);
        chk("tmo_busy_after", busy, 0);
        chk("tmo_count", count, 0);
        chk("tmo_perr", parity_err, 0);
        chk("tmo_ferr", frame_err, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        pop_check("tmo_next");

        // Reset mid-frame with a byte queued and a flag set
        send_frame(8'h3A, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        chk("mr_pre_count", count, 1);
        chk("mr_pre_perr", parity_err, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0, 8'h00);
        chk("mr_pre_busy", busy, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        exp_q.delete();
        chk("mr_data", data, 8'h00);
        chk("mr_empty", empty, 1);
        chk("mr_full", full, 0);
        chk("mr_count", count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_perr", parity_err, 0);
        chk("mr_ferr", frame_err, 0);
        chk("mr_ovf", overflow, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        chk("mr_next_count", count, 1);
        pop_check("mr_next");
        chk("mr_next_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
